aes_block_sequencer: RTL and testbench

- Parametrised block-level controller for the AES HWPE. It sequences word-granular input fetches, the engine crypt phase and word-granular output writes for an arbitrary-length buffer.
- Block size, word size, address width and length width are generics.
- It handles a short final block and rejects malformed lengths.
- It sits between the register file / slave control and the input-source and output-sink streamers.

---
 rtl/aes_block_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_aes_block_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_block_sequencer.sv
// Block-level controller for the AES HWPE: walks a byte buffer block by block,
// fetching input words, running the engine and writing the output words back.
module aes_block_sequencer #(
  parameter int unsigned WORD_BYTES      = 4,
  parameter int unsigned WORDS_PER_BLOCK = 4,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned LEN_W           = 32,
  parameter int unsigned BLK_CNT_W       = 16
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               clear,
  input  logic                               start_i,
  input  logic [ADDR_W-1:0]                  in_base_i,
  input  logic [ADDR_W-1:0]                  out_base_i,
  input  logic [LEN_W-1:0]                   byte_len_i,
  output logic                               in_req_start_o,
  input  logic                               in_ready_start_i,
  input  logic                               in_done_i,
  output logic [ADDR_W-1:0]                  in_addr_o,
  output logic                               out_req_start_o,
  input  logic                               out_ready_start_i,
  input  logic                               out_done_i,
  output logic [ADDR_W-1:0]                  out_addr_o,
  output logic                               eng_start_o,
  output logic                               eng_clear_o,
  input  logic                               eng_done_i,
  output logic [$clog2(WORDS_PER_BLOCK):0]   word_idx_o,
  output logic [BLK_CNT_W-1:0]               block_idx_o,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               err_o
);

  localparam int unsigned WIDX_W = $clog2(WORDS_PER_BLOCK) + 1;
  localparam int unsigned WB_LG  = $clog2(WORD_BYTES);
  localparam int unsigned BB     = WORD_BYTES * WORDS_PER_BLOCK;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_LOAD     = 4'd1;
  localparam logic [3:0] S_REQ_IN   = 4'd2;
  localparam logic [3:0] S_WAIT_IN  = 4'd3;
  localparam logic [3:0] S_CRYPT    = 4'd4;
  localparam logic [3:0] S_REQ_OUT  = 4'd5;
  localparam logic [3:0] S_WAIT_OUT = 4'd6;
  localparam logic [3:0] S_NEXT_BLK = 4'd7;
  localparam logic [3:0] S_FINISH   = 4'd8;
  localparam logic [3:0] S_ERROR    = 4'd9;

  logic [3:0]           state_q, state_d;
  logic [ADDR_W-1:0]    in_base_q, in_base_d, out_base_q, out_base_d;
  logic [LEN_W-1:0]     rem_q, rem_d, rem_next;
  logic [WIDX_W-1:0]    nw_q, nw_d, word_idx_q, word_idx_d;
  logic [BLK_CNT_W-1:0] block_idx_q, block_idx_d;
  logic                 last_word;
  logic                 in_req_d, out_req_d, eng_start_d, eng_clear_d;
  logic                 busy_d, done_d, err_d;

  assign last_word = (word_idx_q == nw_q - WIDX_W'(1));
  assign rem_next  = rem_q - (LEN_W'(nw_q) << WB_LG);

  // Word addresses are pure functions of the latched bases and the counters
  assign in_addr_o   = in_base_q + ADDR_W'(block_idx_q) * ADDR_W'(BB)
                     + ADDR_W'(word_idx_q) * ADDR_W'(WORD_BYTES);
  assign out_addr_o  = out_base_q + ADDR_W'(block_idx_q) * ADDR_W'(BB)
                     + ADDR_W'(word_idx_q) * ADDR_W'(WORD_BYTES);
  assign word_idx_o  = word_idx_q;
  assign block_idx_o = block_idx_q;

  // Next-state, datapath and output decode
  always_comb begin
    state_d     = state_q;
    in_base_d   = in_base_q;
    out_base_d  = out_base_q;
    rem_d       = rem_q;
    nw_d        = nw_q;
    word_idx_d  = word_idx_q;
    block_idx_d = block_idx_q;
    eng_start_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          in_base_d   = in_base_i;
          out_base_d  = out_base_i;
          rem_d       = byte_len_i;
          word_idx_d  = '0;
          block_idx_d = '0;
          if (byte_len_i == '0)
            state_d = S_FINISH;
          else if ((byte_len_i & LEN_W'(WORD_BYTES - 1)) != '0)
            state_d = S_ERROR;
          else
            state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        nw_d       = (rem_q >= LEN_W'(BB)) ? WIDX_W'(WORDS_PER_BLOCK)
                                            : WIDX_W'(rem_q >> WB_LG);
        word_idx_d = '0;
        state_d    = S_REQ_IN;
      end
      S_REQ_IN: if (in_ready_start_i) state_d = S_WAIT_IN;
      S_WAIT_IN: begin
        if (in_done_i) begin
          if (last_word) begin
            word_idx_d  = '0;
            eng_start_d = 1'b1;
            state_d     = S_CRYPT;
          end else begin
            word_idx_d = word_idx_q + WIDX_W'(1);
            state_d    = S_REQ_IN;
          end
        end
      end
      S_CRYPT: if (eng_done_i) state_d = S_REQ_OUT;
      S_REQ_OUT: if (out_ready_start_i) state_d = S_WAIT_OUT;
      S_WAIT_OUT: begin
        if (out_done_i) begin
          if (last_word) begin
            word_idx_d = '0;
            state_d    = S_NEXT_BLK;
          end else begin
            word_idx_d = word_idx_q + WIDX_W'(1);
            state_d    = S_REQ_OUT;
          end
        end
      end
      S_NEXT_BLK: begin
        rem_d       = rem_next;
        block_idx_d = block_idx_q + BLK_CNT_W'(1);
        state_d     = (rem_next == '0) ? S_FINISH : S_LOAD;
      end
      S_FINISH: state_d = S_IDLE;
      S_ERROR:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (clear) begin
      state_d     = S_IDLE;
      in_base_d   = '0;
      out_base_d  = '0;
      rem_d       = '0;
      nw_d        = '0;
      word_idx_d  = '0;
      block_idx_d = '0;
      eng_start_d = 1'b0;
    end

    // Moore outputs registered from the next state so they line up with it
    in_req_d    = (state_d == S_REQ_IN);
    out_req_d   = (state_d == S_REQ_OUT);
    eng_clear_d = (state_d == S_IDLE) || (state_d == S_NEXT_BLK);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_FINISH);
    err_d       = (state_d == S_ERROR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      in_base_q       <= '0;
      out_base_q      <= '0;
      rem_q           <= '0;
      nw_q            <= '0;
      word_idx_q      <= '0;
      block_idx_q     <= '0;
      in_req_start_o  <= 1'b0;
      out_req_start_o <= 1'b0;
      eng_start_o     <= 1'b0;
      eng_clear_o     <= 1'b0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      err_o           <= 1'b0;
    end else begin
      state_q         <= state_d;
      in_base_q       <= in_base_d;
      out_base_q      <= out_base_d;
      rem_q           <= rem_d;
      nw_q            <= nw_d;
      word_idx_q      <= word_idx_d;
      block_idx_q     <= block_idx_d;
      in_req_start_o  <= in_req_d;
      out_req_start_o <= out_req_d;
      eng_start_o     <= eng_start_d;
      eng_clear_o     <= eng_clear_d;
      busy_o          <= busy_d;
      done_o          <= done_d;
      err_o           <= err_d;
    end
  end

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Scoreboard bench for aes_block_sequencer: directed jobs on a 4x4-byte instance
// and an address-wrapping job on an 8x2-byte instance.
module tb_aes_block_sequencer;

  localparam byte EV_DONE = 8'h44;
  localparam byte EV_ERR  = 8'h45;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // instance A: 4-byte words, 4 words per block
  logic        clear_a, start_a, in_ready_a, in_done_a, out_ready_a, out_done_a, eng_done_a;
  logic [31:0] in_base_a, out_base_a, len_a, in_addr_a, out_addr_a;
  logic        in_req_a, out_req_a, eng_start_a, eng_clear_a, busy_a, done_a, err_a;
  logic [2:0]  word_idx_a;
  logic [15:0] block_idx_a;

  aes_block_sequencer #(.WORD_BYTES(4), .WORDS_PER_BLOCK(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .clear(clear_a), .start_i(start_a),
    .in_base_i(in_base_a), .out_base_i(out_base_a), .byte_len_i(len_a),
    .in_req_start_o(in_req_a), .in_ready_start_i(in_ready_a), .in_done_i(in_done_a),
    .in_addr_o(in_addr_a), .out_req_start_o(out_req_a), .out_ready_start_i(out_ready_a),
    .out_done_i(out_done_a), .out_addr_o(out_addr_a), .eng_start_o(eng_start_a),
    .eng_clear_o(eng_clear_a), .eng_done_i(eng_done_a), .word_idx_o(word_idx_a),
    .block_idx_o(block_idx_a), .busy_o(busy_a), .done_o(done_a), .err_o(err_a)
  );

  // instance B: 8-byte words, 2 words per block
  logic        clear_b, start_b, in_ready_b, in_done_b, out_ready_b, out_done_b, eng_done_b;
  logic [31:0] in_base_b, out_base_b, len_b, in_addr_b, out_addr_b;
  logic        in_req_b, out_req_b, eng_start_b, eng_clear_b, busy_b, done_b, err_b;
  logic [1:0]  word_idx_b;
  logic [15:0] block_idx_b;

  aes_block_sequencer #(.WORD_BYTES(8), .WORDS_PER_BLOCK(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .clear(clear_b), .start_i(start_b),
    .in_base_i(in_base_b), .out_base_i(out_base_b), .byte_len_i(len_b),
    .in_req_start_o(in_req_b), .in_ready_start_i(in_ready_b), .in_done_i(in_done_b),
    .in_addr_o(in_addr_b), .out_req_start_o(out_req_b), .out_ready_start_i(out_ready_b),
    .out_done_i(out_done_b), .out_addr_o(out_addr_b), .eng_start_o(eng_start_b),
    .eng_clear_o(eng_clear_b), .eng_done_i(eng_done_b), .word_idx_o(word_idx_b),
    .block_idx_o(block_idx_b), .busy_o(busy_b), .done_o(done_b), .err_o(err_b)
  );

  logic [31:0] q_in_a[$], q_out_a[$], q_in_b[$], q_out_b[$];
  byte         q_evt_a[$], q_evt_b[$];
  int          stall_cfg, eng_delay_cfg;
  int          in_hs_a = 0, out_hs_a = 0, eng_starts_a = 0, stall_seen_a = 0, done_cyc_a = 0;
  int          eng_starts_b = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string nm, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=%0h required=none (t=%0t)", nm, act, $time);
  endtask

  // streamer and engine model for instance A
  initial begin : resp_a
    int stall_cnt, eng_cnt;
    bit pend_in, pend_out, eng_pend;
    stall_cnt = 0; eng_cnt = 0; pend_in = 0; pend_out = 0; eng_pend = 0;
    in_ready_a = 0; in_done_a = 0; out_ready_a = 0; out_done_a = 0; eng_done_a = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        stall_cnt = 0; pend_in = 0; pend_out = 0; eng_pend = 0;
        in_ready_a = 0; in_done_a = 0; out_ready_a = 0; out_done_a = 0; eng_done_a = 0;
      end else begin
        in_done_a  = pend_in;  pend_in  = 0;
        out_done_a = pend_out; pend_out = 0;
        if (!busy_a) stall_cnt = 0;
        in_ready_a = in_req_a && (stall_cnt >= stall_cfg);
        if (in_req_a && !in_ready_a) stall_cnt++;
        if (in_ready_a) pend_in = 1;
        out_ready_a = out_req_a;
        if (out_ready_a) pend_out = 1;
        eng_done_a = 0;
        if (eng_start_a) begin eng_pend = 1; eng_cnt = eng_delay_cfg; end
        if (eng_pend) begin
          if (eng_cnt == 0) begin eng_done_a = 1; eng_pend = 0; end
          else eng_cnt--;
        end
      end
    end
  end

  // scoreboard monitor for instance A
  initial begin : mon_a
    logic [31:0] e;
    byte ev;
    forever begin
      @(negedge clk); #2;
      if (reset_n) begin
        if (in_req_a && in_ready_a) begin
          in_hs_a++;
          if (q_in_a.size() == 0) unexpected("a_in_req", in_addr_a);
          else begin e = q_in_a.pop_front(); chk("a_in_addr", in_addr_a, e); end
        end
        if (out_req_a && out_ready_a) begin
          out_hs_a++;
          if (q_out_a.size() == 0) unexpected("a_out_req", out_addr_a);
          else begin e = q_out_a.pop_front(); chk("a_out_addr", out_addr_a, e); end
        end
        if (in_req_a && !in_ready_a) stall_seen_a++;
        if (eng_start_a) eng_starts_a++;
        if (done_a || err_a) begin
          if (done_a) done_cyc_a = cyc;
          if (q_evt_a.size() == 0) unexpected(done_a ? "a_done" : "a_err", 32'(block_idx_a));
          else begin ev = q_evt_a.pop_front(); chk("a_event", done_a ? EV_DONE : EV_ERR, ev); end
        end
      end
    end
  end

  // always-ready streamers and zero-latency engine for instance B
  initial begin : resp_b
    bit pi, po;
    pi = 0; po = 0;
    in_ready_b = 0; in_done_b = 0; out_ready_b = 0; out_done_b = 0; eng_done_b = 0;
    forever begin
      @(negedge clk);
      in_done_b   = pi;
      out_done_b  = po;
      in_ready_b  = in_req_b;
      out_ready_b = out_req_b;
      pi          = in_req_b;
      po          = out_req_b;
      eng_done_b  = eng_start_b;
    end
  end

  initial begin : mon_b
    logic [31:0] e;
    forever begin
      @(negedge clk); #2;
      if (reset_n) begin
        if (in_req_b && in_ready_b) begin
          if (q_in_b.size() == 0) unexpected("b_in_req", in_addr_b);
          else begin e = q_in_b.pop_front(); chk("b_in_addr", in_addr_b, e); end
        end
        if (out_req_b && out_ready_b) begin
          if (q_out_b.size() == 0) unexpected("b_out_req", out_addr_b);
          else begin e = q_out_b.pop_front(); chk("b_out_addr", out_addr_b, e); end
        end
        if (eng_start_b) eng_starts_b++;
        if (done_b || err_b) begin
          if (q_evt_b.size() == 0) unexpected("b_event", 32'(err_b));
          else begin void'(q_evt_b.pop_front()); chk("b_err", err_b, 1'b0); end
        end
      end
    end
  end

  task automatic push_words(input bit is_in, input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      if (is_in) q_in_a.push_back(base + 32'(4 * i));
      else       q_out_a.push_back(base + 32'(4 * i));
    end
  endtask

  task automatic start_job_a(input logic [31:0] len, output int scyc);
    @(negedge clk);
    in_base_a = 32'h1000; out_base_a = 32'h2000; len_a = len; start_a = 1'b1;
    scyc = cyc;
    @(negedge clk);
    start_a = 1'b0;
    #3;
  endtask

  task automatic run_job_a(input logic [31:0] len, input int exp_starts, input byte ev);
    int s0, scyc, t;
    s0 = eng_starts_a;
    eng_delay_cfg = $urandom_range(0, 20);
    q_evt_a.push_back(ev);
    start_job_a(len, scyc);
    t = 0;
    while ((q_evt_a.size() != 0 || q_in_a.size() != 0 || q_out_a.size() != 0) && t < 2000) begin
      @(negedge clk); #3; t++;
    end
    chk("a_job_events_left", 32'(q_evt_a.size()), 0);
    chk("a_job_in_left", 32'(q_in_a.size()), 0);
    chk("a_eng_starts", 32'(eng_starts_a - s0), 32'(exp_starts));
    @(negedge clk); #3;
    chk("a_busy_after_end", busy_a, 1'b0);
    chk("a_done_one_cycle", done_a, 1'b0);
  endtask

  initial begin : main
    int scyc, t, s0, h0;
    reset_n = 0;
    clear_a = 0; start_a = 0; in_base_a = 0; out_base_a = 0; len_a = 0;
    clear_b = 0; start_b = 0; in_base_b = 0; out_base_b = 0; len_b = 0;
    stall_cfg = 0; eng_delay_cfg = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_eng_clear", eng_clear_a, 1'b0);
    chk("rst_in_req", in_req_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_in_addr", in_addr_a, 32'h0);
    chk("rst_block_idx", block_idx_a, 16'h0);
    @(negedge clk);
    reset_n = 1;
    @(negedge clk); #3;
    chk("idle_eng_clear", eng_clear_a, 1'b1);
    chk("idle_busy", busy_a, 1'b0);

    // two full blocks
    push_words(1, 32'h1000, 8);
    push_words(0, 32'h2000, 8);
    run_job_a(32, 2, EV_DONE);

    // full block plus a one-word tail
    push_words(1, 32'h1000, 5);
    push_words(0, 32'h2000, 5);
    run_job_a(20, 2, EV_DONE);

    // empty job completes without requests
    s0 = in_hs_a;
    q_evt_a.push_back(EV_DONE);
    start_job_a(0, scyc);
    chk("zero_len_done_seen", 32'(q_evt_a.size()), 0);
    chk("zero_len_latency_ok", (done_cyc_a - scyc >= 1) && (done_cyc_a - scyc <= 2), 1'b1);
    chk("zero_len_no_req", 32'(in_hs_a - s0), 0);
    @(negedge clk); #3;
    chk("zero_len_busy", busy_a, 1'b0);

    // misaligned length is rejected
    run_job_a(6, 0, EV_ERR);
    chk("misaligned_no_req", 32'(in_hs_a - s0), 0);

    // first input request stalled for five cycles
    stall_cfg = 5;
    s0 = stall_seen_a;
    push_words(1, 32'h1000, 4);
    push_words(0, 32'h2000, 4);
    run_job_a(16, 1, EV_DONE);
    chk("stall_cycles", 32'(stall_seen_a - s0), 32'd5);
    stall_cfg = 0;

    // soft clear during the first output word of block 1
    h0 = out_hs_a;
    push_words(1, 32'h1000, 8);
    push_words(0, 32'h2000, 5);
    start_job_a(32, scyc);
    t = 0;
    while (out_hs_a < h0 + 5 && t < 2000) begin @(negedge clk); #3; t++; end
    chk("clr_reached_block1", block_idx_a, 16'd1);
    @(negedge clk);
    clear_a = 1'b1;
    @(posedge clk); #1;
    chk("clr_busy", busy_a, 1'b0);
    chk("clr_block_idx", block_idx_a, 16'd0);
    chk("clr_word_idx", word_idx_a, 3'd0);
    chk("clr_done", done_a, 1'b0);
    @(negedge clk);
    clear_a = 1'b0;
    repeat (3) @(negedge clk);
    chk("clr_out_left", 32'(q_out_a.size()), 0);
    push_words(1, 32'h1000, 5);
    push_words(0, 32'h2000, 5);
    run_job_a(20, 2, EV_DONE);

    // asynchronous reset while the engine is running
    eng_delay_cfg = 15;
    s0 = eng_starts_a;
    push_words(1, 32'h1000, 4);
    in_base_a = 32'h1000; out_base_a = 32'h2000; len_a = 16;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    t = 0;
    while (eng_starts_a == s0 && t < 2000) begin @(negedge clk); #3; t++; end
    chk("crypt_reached", 32'(eng_starts_a - s0), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_busy", busy_a, 1'b0);
    chk("arst_eng_start", eng_start_a, 1'b0);
    chk("arst_eng_clear", eng_clear_a, 1'b0);
    chk("arst_out_req", out_req_a, 1'b0);
    chk("arst_in_addr", in_addr_a, 32'h0);
    chk("arst_out_addr", out_addr_a, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("arst_in_left", 32'(q_in_a.size()), 0);

    // wide words with an input address that wraps past the top of memory
    q_in_b.push_back(32'hFFFF_FFF0); q_in_b.push_back(32'hFFFF_FFF8);
    q_in_b.push_back(32'h0000_0000); q_in_b.push_back(32'h0000_0008);
    q_out_b.push_back(32'h3000); q_out_b.push_back(32'h3008);
    q_out_b.push_back(32'h3010); q_out_b.push_back(32'h3018);
    q_evt_b.push_back(EV_DONE);
    s0 = eng_starts_b;
    @(negedge clk);
    in_base_b = 32'hFFFF_FFF0; out_base_b = 32'h3000; len_b = 32; start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    t = 0;
    while ((q_evt_b.size() != 0 || q_in_b.size() != 0 || q_out_b.size() != 0) && t < 2000) begin
      @(negedge clk); #3; t++;
    end
    chk("b_events_left", 32'(q_evt_b.size()), 0);
    chk("b_in_left", 32'(q_in_b.size()), 0);
    chk("b_eng_starts", 32'(eng_starts_b - s0), 32'd2);
    @(negedge clk); #3;
    chk("b_busy_after_end", busy_b, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
